// File: rtl/game_pkg.sv
// Shared definitions for the stacking game: screen geometry, colours and
// the block drawer state encoding.
package game_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BLOCK_H  = 8;

  typedef logic [2:0] colour_t;

  localparam colour_t BG_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERASE,
    ST_DRAW,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rect_scanner.sv
// Row-major rectangle walker shared by the erase and draw phases. A load
// captures the base corner and width and rewinds to the top-left pixel;
// each advance steps one pixel. The address is formed one bit wider than
// the screen so off-screen pixels are flagged rather than wrapped.
module rect_scanner #(
  parameter int BLOCK_H  = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] base_x,
  input  logic [6:0] base_y,
  input  logic [7:0] width,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic       pix_valid,
  output logic       last
);

  logic [7:0] bx_q, bx_d;
  logic [6:0] by_q, by_d;
  logic [7:0] bw_q, bw_d;
  logic [7:0] col_q, col_d;
  logic [6:0] row_q, row_d;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  // Next base/counter values: load rewinds, advance steps along the row.
  always_comb begin
    bx_d  = bx_q;
    by_d  = by_q;
    bw_d  = bw_q;
    col_d = col_q;
    row_d = row_q;
    if (load) begin
      bx_d  = base_x;
      by_d  = base_y;
      bw_d  = width;
      col_d = 8'd0;
      row_d = 7'd0;
    end else if (advance) begin
      if (col_q == bw_q - 8'd1) begin
        col_d = 8'd0;
        row_d = row_q + 7'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  // Scanner registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bx_q  <= 8'd0;
      by_q  <= 7'd0;
      bw_q  <= 8'd0;
      col_q <= 8'd0;
      row_q <= 7'd0;
    end else begin
      bx_q  <= bx_d;
      by_q  <= by_d;
      bw_q  <= bw_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Wide pixel address, clip test and end-of-rectangle flag.
  always_comb begin
    sum_x     = {1'b0, bx_q} + {1'b0, col_q};
    sum_y     = {1'b0, by_q} + {1'b0, row_q};
    pix_x     = sum_x[7:0];
    pix_y     = sum_y[6:0];
    pix_valid = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
    last      = (col_q == bw_q - 8'd1) && (row_q == 7'(BLOCK_H - 1));
  end

endmodule

// File: rtl/block_drawer.sv
// Erases the previously drawn block in the background colour, then draws
// the newly requested one, one pixel per clock into the VGA write port.
import game_pkg::*;

module block_drawer #(
  parameter int      BLOCK_H   = game_pkg::BLOCK_H,
  parameter int      SCREEN_W  = game_pkg::SCREEN_W,
  parameter int      SCREEN_H  = game_pkg::SCREEN_H,
  parameter colour_t BG_COLOUR = game_pkg::BG_COLOUR
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       commit,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  input  logic [7:0] width_in,
  input  logic [2:0] colour_in,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  state_t     state_q, state_d;
  logic [7:0] nx_q, nx_d, nw_q, nw_d;
  logic [6:0] ny_q, ny_d;
  colour_t    nc_q, nc_d;
  logic [7:0] old_x_q, old_x_d, old_w_q, old_w_d;
  logic [6:0] old_y_q, old_y_d;
  logic       old_valid_q, old_valid_d, pend_q, pend_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  colour_t    vga_colour_q, vga_colour_d;
  logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic       scan_load, scan_adv;
  logic [7:0] ld_x, ld_w, scan_x;
  logic [6:0] ld_y, scan_y;
  logic       scan_valid, scan_last;

  rect_scanner #(
    .BLOCK_H (BLOCK_H),
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_scanner (
    .clk      (clk),
    .resetn   (resetn),
    .load     (scan_load),
    .advance  (scan_adv),
    .base_x   (ld_x),
    .base_y   (ld_y),
    .width    (ld_w),
    .pix_x    (scan_x),
    .pix_y    (scan_y),
    .pix_valid(scan_valid),
    .last     (scan_last)
  );

  // Next state, old-block bookkeeping and the next registered pixel outputs.
  always_comb begin
    state_d      = state_q;
    nx_d         = nx_q;
    ny_d         = ny_q;
    nw_d         = nw_q;
    nc_d         = nc_q;
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    old_w_d      = old_w_q;
    old_valid_d  = old_valid_q;
    pend_d       = pend_q;
    scan_load    = 1'b0;
    scan_adv     = 1'b0;
    ld_x         = nx_q;
    ld_y         = ny_q;
    ld_w         = nw_q;
    vga_x_d      = 8'd0;
    vga_y_d      = 7'd0;
    vga_colour_d = 3'b000;
    plot_d       = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (commit) old_valid_d = 1'b0;
        if (start) begin
          nx_d = x_in;
          ny_d = y_in;
          nw_d = width_in;
          nc_d = colour_in;
          if (old_valid_q && !commit && (old_w_q != 8'd0)) begin
            state_d   = ST_ERASE;
            scan_load = 1'b1;
            ld_x      = old_x_q;
            ld_y      = old_y_q;
            ld_w      = old_w_q;
          end else if (width_in != 8'd0) begin
            state_d   = ST_DRAW;
            scan_load = 1'b1;
            ld_x      = x_in;
            ld_y      = y_in;
            ld_w      = width_in;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_ERASE: begin
        vga_x_d      = scan_x;
        vga_y_d      = scan_y;
        vga_colour_d = BG_COLOUR;
        plot_d       = scan_valid;
        busy_d       = 1'b1;
        scan_adv     = 1'b1;
        if (commit) pend_d = 1'b1;
        if (scan_last) begin
          if (nw_q != 8'd0) begin
            state_d   = ST_DRAW;
            scan_load = 1'b1;
          end else begin
            state_d = ST_DONE;
            if (pend_q || commit) old_valid_d = 1'b0;
            pend_d = 1'b0;
          end
        end
      end

      ST_DRAW: begin
        vga_x_d      = scan_x;
        vga_y_d      = scan_y;
        vga_colour_d = nc_q;
        plot_d       = scan_valid;
        busy_d       = 1'b1;
        scan_adv     = 1'b1;
        if (commit) pend_d = 1'b1;
        if (scan_last) begin
          state_d     = ST_DONE;
          old_x_d     = nx_q;
          old_y_d     = ny_q;
          old_w_d     = nw_q;
          old_valid_d = !(pend_q || commit);
          pend_d      = 1'b0;
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (commit) old_valid_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request, old record and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      nx_q         <= 8'd0;
      ny_q         <= 7'd0;
      nw_q         <= 8'd0;
      nc_q         <= 3'b000;
      old_x_q      <= 8'd0;
      old_y_q      <= 7'd0;
      old_w_q      <= 8'd0;
      old_valid_q  <= 1'b0;
      pend_q       <= 1'b0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'b000;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      nx_q         <= nx_d;
      ny_q         <= ny_d;
      nw_q         <= nw_d;
      nc_q         <= nc_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      old_w_q      <= old_w_d;
      old_valid_q  <= old_valid_d;
      pend_q       <= pend_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/block_drawer.md
# block_drawer

Pixel-serial renderer for the moving block of the stacking game. It sits between the game-logic registers that produce the block's current x position (plus y, width and colour) and the VGA adapter's single-pixel write port. On each `start` request it first erases the rectangle it drew last time, painting it in the background colour, then draws the new rectangle, emitting exactly one pixel per clock.

## Interface
Parameters:
- BLOCK_H, 8: block height in pixel rows (1..120).
- SCREEN_W, 160: visible width; pixels with x ≥ SCREEN_W are clipped.
- SCREEN_H, 120: visible height; pixels with y ≥ SCREEN_H are clipped.
- BG_COLOUR, 3'b000: colour used for erase.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk  in  1  50 MHz system clock.
  - resetn  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- commit  in  1  marks the last-drawn block as placed, so the next request does not erase it.
- x_in  in  8  left column of the new block (from the x register).
- y_in  in  7  top row of the new block.
- width_in  in  8  block width in pixels (0..160).
- colour_in  in  3  block colour.
- vga_x  out  8  pixel column.
- vga_y  out  7  pixel row.
- vga_colour  out  3  pixel colour.
- plot  out  1  pixel write strobe.
- busy  out  1  high while in ERASE or DRAW.
- done  out  1  one-cycle completion pulse.

## Operation
- Internal "old" record:
  - old_x, old_y, old_w, plus old_valid.
  - Reset value: old_valid = 0.
- States are IDLE, ERASE, DRAW and DONE.
- IDLE:
  - On `start`, latch x_in, y_in, width_in and colour_in.
  - If old_valid and old_w ≠ 0, go to ERASE.
  - Otherwise, if width_in ≠ 0, go to DRAW.
  - Otherwise, go to DONE.
- ERASE:
  - Scan the old rectangle row-major: columns 0..old_w-1 within each row, rows 0..BLOCK_H-1.
  - One pixel per cycle, vga_colour = BG_COLOUR.
  - After the last pixel, go to DRAW (or to DONE if the latched width is 0).
- DRAW:
  - Scan the latched rectangle the same way with the latched colour.
  - After the last pixel, copy the latched parameters into the old record, set old_valid = 1, and go to DONE.
- DONE:
  - done = 1 for one cycle, then IDLE.
- Clipping:
  - Pixel address is computed 9 bits wide (x + col) and 8 bits wide (y + row).
  - If either exceeds its limit, plot = 0 but the scan slot still consumes one cycle, so cycle counts are deterministic.
  - Clipped pixels never wrap to column 0.
- commit:
  - In IDLE or DONE: clears old_valid immediately.
  - During ERASE or DRAW: sets a pending flag. At the DRAW→DONE transition the pending flag clears old_valid instead of setting it, and the flag self-clears.
  - commit and start in the same IDLE cycle: commit applies first, so no erase happens.
- `start` outside IDLE is ignored (not queued).
- Reset mid-operation:
  - Returns to IDLE and zeroes all outputs.
  - old_valid = 0; the partially drawn rectangle is not erased.

## Timing
- All outputs are registered.
- Reset values: vga_x = 0, vga_y = 0, vga_colour = 0, plot = 0, busy = 0, done = 0.
- Latency: `start` sampled at edge k → first pixel (plot = 1) valid after edge k+1.
- Busy duration: pixels are emitted back-to-back, N_e = old_w·BLOCK_H erase cycles then N_d = width·BLOCK_H draw cycles, with no gap.
- busy is high for exactly N_e + N_d cycles.
- done is high in the cycle after the last pixel; busy is low in that cycle.
- Zero-size request (N_e = N_d = 0): done is asserted in cycle k+1 with no plot.
- plot = 0 whenever state ≠ ERASE/DRAW.
- The earliest accepted next `start` is the cycle after done.

## Structure
- Shared game package `game_pkg` holds:
  - SCREEN_W, SCREEN_H, BG_COLOUR, BLOCK_H.
  - Colour typedef (3 bits).
  - FSM state enum.
- Sub-module `rect_scanner`, reused for both ERASE and DRAW:
  - Inputs: base x/y, width and a load strobe.
  - Generates col/row counters, the clipped pixel address, a valid bit and a `last` flag.
- The FSM lives in block_drawer.

## Test plan
- Reset:
  - Stimulus: hold resetn = 0 for 3 cycles with start = 1.
  - Required: all outputs are 0, no plot, and old_valid = 0.
- First draw:
  - Stimulus: x = 10, y = 100, w = 4, colour = 3'b100.
  - Required: 32 plots in order (10,100),(11,100)…(13,107) with colour 100; done 33 cycles after start; busy high 32 cycles.
- Move:
  - Stimulus: next start with x = 11 (other fields unchanged).
  - Required: 32 erase plots over x 10..13 with colour 000, then 32 draw plots over x 11..14; done at cycle 65.
- Commit:
  - Stimulus: commit, then start with x = 20.
  - Required: no erase phase; 32 draw plots only; the previous block's pixels are untouched.
- Clip:
  - Stimulus: x = 158, w = 4.
  - Required: 32 busy cycles; plot high only for x = 158 and x = 159 (16 plots); no pixel at x = 0 or x = 1.
- Abuse:
  - Stimulus: start pulsed mid-DRAW, then resetn pulsed mid-DRAW.
  - Required: the extra start has no effect; reset yields IDLE on the next cycle with outputs 0, and the following start performs no erase.
